// File: rtl/jt12_fnum_seq.sv
// ---------------------------------------------------------------------------
// jt12_fnum_seq
//
// Purpose:
//   CPU-facing writer and slot sequencer for the phase generator's frequency
//   inputs. Captures F-number/block register writes (A0-A6 per part, plus the
//   channel-3 special-mode registers A8-AE on part 0) including the YM2612
//   hi-byte latch behaviour, and replays the stored values as a 24-slot
//   time-multiplexed fnum/block stream (6 channels x 4 operator groups).
//
// Optional feature:
//   `define JT12_CH3_SPECIAL_EN to build the channel-3 special-mode storage
//   (sp[0..2], sp_latch) and honour ch3_mode. Without it, A8-AE writes and
//   ch3_mode are ignored and channel 2 always uses its normal entry.
//
// Parameters:
//   OUT_REG  1 = extra output register stage (latency 2 clk_en cycles),
//            0 = single output stage (latency 1 clk_en cycle)
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   clk_en    clock enable for the slot counter and output pipeline
//   zero      slot-sync pulse, forces the counter back to slot 0
//   wr_en     one-cycle register write strobe (not gated by clk_en)
//   wr_part   0 = channels 0-2, 1 = channels 3-5
//   wr_addr   register address
//   din       write data
//   ch3_mode  channel 2 special mode (per-operator frequencies)
//   fnum_I    F-number for the current slot
//   block_I   block for the current slot
//   slot_ch   channel (0-5) of the value on fnum_I
//   slot_op   operator group (0..3 = S1,S3,S2,S4) of the value on fnum_I
// ---------------------------------------------------------------------------
module jt12_fnum_seq #(
   parameter int OUT_REG = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clk_en,
   input  logic        zero,
   input  logic        wr_en,
   input  logic        wr_part,
   input  logic [7:0]  wr_addr,
   input  logic [7:0]  din,
   input  logic        ch3_mode,
   output logic [10:0] fnum_I,
   output logic [2:0]  block_I,
   output logic [2:0]  slot_ch,
   output logic [1:0]  slot_op
);

   // Stored values are packed as {block[2:0], fnum[10:0]}.
   localparam int W = 14;

   // Register address groups (wr_addr[7:2]); low two bits pick the channel.
   localparam logic [5:0] GRP_FLO = 6'b101000;   // A0-A2
   localparam logic [5:0] GRP_FHI = 6'b101001;   // A4-A6
   localparam logic [5:0] GRP_SLO = 6'b101010;   // A8-AA
   localparam logic [5:0] GRP_SHI = 6'b101011;   // AC-AE

   logic [5:0]   hi_latch;
   logic [W-1:0] entry [0:5];

   logic [1:0]   wr_c;
   logic         wr_c_ok;
   logic [2:0]   wr_ch;
   logic [5:0]   wr_grp;

   logic [2:0]   cnt_ch;
   logic [1:0]   cnt_op;

   logic [W-1:0] sel_val;

   logic [W-1:0] s1_val;
   logic [2:0]   s1_ch;
   logic [1:0]   s1_op;

   assign wr_c    = wr_addr[1:0];
   assign wr_c_ok = (wr_c != 2'd3);
   assign wr_ch   = {1'b0, wr_c} + (wr_part ? 3'd3 : 3'd0);
   assign wr_grp  = wr_addr[7:2];

   // Normal channel registers. The hi-byte write only loads the shared latch;
   // the low-byte write commits latch+data into the channel entry and leaves
   // the latch alone, so one hi write can be reused for several channels.
   // Writes are deliberately not qualified by clk_en.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_latch <= '0;
         for (int i = 0; i < 6; i++) begin
            entry[i] <= '0;
         end
      end else if (wr_en && wr_c_ok) begin
         if (wr_grp == GRP_FHI) begin
            hi_latch <= din[5:0];
         end
         if (wr_grp == GRP_FLO) begin
            entry[wr_ch] <= {hi_latch, din};
         end
      end
   end

`ifdef JT12_CH3_SPECIAL_EN
   logic [5:0]   sp_latch;
   logic [W-1:0] sp [0:2];

   // Channel-3 special-mode registers exist only on part 0. They keep their
   // contents while ch3_mode is off so re-enabling the mode restores them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp_latch <= '0;
         for (int i = 0; i < 3; i++) begin
            sp[i] <= '0;
         end
      end else if (wr_en && wr_c_ok && !wr_part) begin
         if (wr_grp == GRP_SHI) begin
            sp_latch <= din[5:0];
         end
         if (wr_grp == GRP_SLO) begin
            sp[wr_c] <= {sp_latch, din};
         end
      end
   end
`else
   logic unused_ch3_mode;
   assign unused_ch3_mode = ch3_mode;
`endif

   // Slot counter kept as separate channel and operator-group fields; the
   // linear slot number is op*6 + ch, so stepping ch 0..5 and carrying into op
   // gives the 0..23 sequence, and the 2-bit op wraps 3 -> 0 on its own.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_ch <= '0;
         cnt_op <= '0;
      end else if (clk_en) begin
         if (zero) begin
            cnt_ch <= '0;
            cnt_op <= '0;
         end else if (cnt_ch == 3'd5) begin
            cnt_ch <= '0;
            cnt_op <= cnt_op + 2'd1;
         end else begin
            cnt_ch <= cnt_ch + 3'd1;
         end
      end
   end

   // Source select for the slot the counter points at. In special mode
   // channel 2's S1/S3/S2 groups come from A9/A8/AA; S4 keeps the normal A2
   // entry, which is why op group 3 falls through to entry[2].
   always_comb begin
      sel_val = entry[cnt_ch];
`ifdef JT12_CH3_SPECIAL_EN
      if (ch3_mode && (cnt_ch == 3'd2)) begin
         case (cnt_op)
            2'd0:    sel_val = sp[1];
            2'd1:    sel_val = sp[0];
            2'd2:    sel_val = sp[2];
            default: sel_val = entry[2];
         endcase
      end
`endif
   end

   // First output stage: value and its slot tag move together so the tag
   // always describes the value beside it. A write landing on the same edge
   // is not visible here until that slot comes round again.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_val <= '0;
         s1_ch  <= '0;
         s1_op  <= '0;
      end else if (clk_en) begin
         s1_val <= sel_val;
         s1_ch  <= cnt_ch;
         s1_op  <= cnt_op;
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out2
         logic [W-1:0] s2_val;
         logic [2:0]   s2_ch;
         logic [1:0]   s2_op;

         // Optional second stage, identical to the first, for timing relief.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s2_val <= '0;
               s2_ch  <= '0;
               s2_op  <= '0;
            end else if (clk_en) begin
               s2_val <= s1_val;
               s2_ch  <= s1_ch;
               s2_op  <= s1_op;
            end
         end

         assign fnum_I  = s2_val[10:0];
         assign block_I = s2_val[13:11];
         assign slot_ch = s2_ch;
         assign slot_op = s2_op;
      end else begin : g_out1
         assign fnum_I  = s1_val[10:0];
         assign block_I = s1_val[13:11];
         assign slot_ch = s1_ch;
         assign slot_op = s1_op;
      end
   endgenerate

endmodule

// File: doc/jt12_fnum_seq.md
Name: jt12_fnum_seq

Overview:
- Writer/sequencer side of the phase generator's frequency inputs.
- Accepts CPU register writes for F-number and block (YM2612 regs A0–A6, and A8–AE for ch3 special mode), including the hi-byte latch behaviour.
- Replays the stored values as the 24-slot time-multiplexed fnum/block stream that the phase generator consumes at its stage I.

Parameters:
- OUT_REG, 1: 1 = outputs registered once more (latency 2 clk_en cycles from slot counter); 0 = latency 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- clk_en  in  1  clock enable; all state advances only when high (reset excepted)
- zero  in  1  slot-sync pulse; sampled on clk_en
- wr_en  in  1  register write strobe, one clk cycle, independent of clk_en
- wr_part  in  1  0 = channels 0–2, 1 = channels 3–5
- wr_addr  in  8  register address
- din  in  8  write data
- ch3_mode  in  1  1 = channel 2 (zero-based) special mode, per-operator frequencies
- fnum_I  out  11  F-number for current slot
- block_I  out  3  block for current slot
- slot_ch  out  3  channel 0–5 of the value on fnum_I
- slot_op  out  2  operator group 0..3 = S1,S3,S2,S4 of the value on fnum_I

Behaviour:
- Reset: all six channel fnum/block entries, the three ch3 special entries, both hi latches and the slot counter clear to 0. fnum_I, block_I, slot_ch and slot_op are all 0.
- Writes (part-local channel c = wr_addr[1:0]; c=3 ignored; global ch = c + 3*wr_part):
  - A4–A6: hi_latch <= din[5:0] (block = din[5:3], fnum[10:8] = din[2:0]). No channel update.
  - A0–A2: entry[ch] <= {hi_latch, din}. hi_latch itself is kept.
  - AC–AE: sp_latch <= din[5:0]; accepted only when wr_part=0.
  - A8–AA: sp[c] <= {sp_latch, din}; accepted only when wr_part=0.
  - Any other address: ignored.
- Write vs. clk_en: writes take effect on the clk edge where wr_en=1, regardless of clk_en.
- Slot counter, 0..23, on each clk_en:
  - if zero=1, next value is 0;
  - else increment, wrapping 23 -> 0.
  - Mapping: ch = cnt mod 6, op group = cnt / 6.
- Source select for the current slot:
  - Default: entry[ch].
  - If ch3_mode=1 and ch=2: S1 -> sp[1] (A9), S3 -> sp[0] (A8), S2 -> sp[2] (AA), S4 -> entry[2] (A2).
- Output registration: selected value plus ch/op are registered on clk_en. With OUT_REG=1 an identical second stage follows. Latency from counter value to outputs is 1 or 2 clk_en cycles; slot_ch/slot_op always stay aligned with fnum_I/block_I.
- Write/read collision: if the read register samples the same entry in the cycle that entry is written, it captures the old value; the new value appears on the next visit to that slot.
- ch3_mode change: takes effect at the next clk_en sample with no glitch. Stored sp entries are kept while ch3_mode=0.
- Reset asserted mid-frame: immediate asynchronous clear. After release, counting resumes from slot 0.

Optional Feature:
- Macro: JT12_CH3_SPECIAL_EN.
- Defined: sp[0..2], sp_latch and the ch3_mode selection behave as above.
- Undefined: no sp storage; A8–AE writes are ignored; ch3_mode is ignored; channel 2 always uses entry[2].

Test Plan:
- Reset, then 48 clk_en cycles with no writes -> fnum_I=0, block_I=0 in every slot; slot_ch cycles 0..5 and slot_op cycles 0..3 in order.
- Write part0 A4=0x22, then A0=0x69 -> channel 0 slots show block_I=4, fnum_I=0x269; all other channels stay 0.
- Write part1 A5=0x1C with no following A1 write -> no output change. Then write part1 A1=0x00 -> channel 4 shows block_I=3, fnum_I=0x400.
- ch3_mode=1; AD=0x0B, A9=0x10; AC=0x03, A8=0x20; AE=0x00, AA=0x05; A6=0x01, A2=0x00 -> channel 2 shows: S1 block 1/fnum 0x310; S3 block 0/fnum 0x320; S2 block 0/fnum 0x005; S4 block 0/fnum 0x100. With ch3_mode=0, all four groups show block 0/fnum 0x100.
- Pulse zero at counter=13 -> next sampled slot is 0 (ch 0, op S1). Separately, with zero never asserted, confirm the wrap 23 -> 0.
- Assert rst_n low mid-frame after the writes above -> outputs go to 0 immediately; after release, all entries read 0 and counting starts at slot 0.
